aim_sched: RTL

- Controller/arbiter in front of the associative-match (AIM) engine.
- Shares the single AIM instance between NUM_REQ requesters using round-robin arbitration.
- Sequences each job: pulses start with the iteration count, waits for finish (with timeout), captures the 32 per-word results, then streams only the hit entries to the granted requester over a valid/ready port.
- Reports hit count and completion per job.

---
 rtl/aim_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/aim_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/aim_pkg.sv
// Shared constants, state encoding and result type for the AIM scheduler.
package aim_pkg;

  localparam int LANES  = 32;
  localparam int LANE_W = 5;
  localparam int POS_W  = 9;
  localparam int ITE_W  = 4;
  localparam int HIT_W  = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [POS_W-1:0]  pos;
  } res_t;

  function automatic logic [HIT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [HIT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + HIT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W:0]   slot;
  logic [PTR_W-1:0] cand;

  // scan NUM_REQ slots starting from ptr, first hit wins
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    slot = '0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, ptr} + (PTR_W+1)'(i);
      if (slot >= (PTR_W+1)'(NUM_REQ)) slot = slot - (PTR_W+1)'(NUM_REQ);
      cand = slot[PTR_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/aim_sched.sv
// Arbitrates requesters onto the single AIM engine, sequences start/finish,
// captures the per-lane results and streams only the hits back out.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no job; arbitrate, latch grant and clamped iteration
//   ST_START | one-cycle start pulse to AIM, timeout counter cleared
//   ST_WAIT  | wait for finish or timeout, capture results on finish
//   ST_DRAIN | stream hit entries, lowest lane first, valid/ready
//   ST_DONE  | one-cycle done pulse, release grant, advance rr pointer
module aim_sched
  import aim_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_ITE = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*ITE_W-1:0] i_req_ite,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic                     o_aim_start,
  output logic [ITE_W-1:0]         o_aim_ite,
  input  logic                     i_aim_finish,
  input  logic [LANES-1:0]         i_aim_valid,
  input  logic [LANES*POS_W-1:0]   i_aim_pos,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [LANE_W-1:0]        o_res_lane,
  output logic [POS_W-1:0]         o_res_pos,
  output logic                     o_done,
  output logic [HIT_W-1:0]         o_hit_cnt,
  output logic                     o_timeout,
  output logic                     o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_q;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [ITE_W-1:0]   ite_req;
  logic [ITE_W-1:0]   ite_clamp;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_next;
  logic [LANES-1:0]   hit_mask;
  logic [LANES-1:0]   mask_next;
  logic [HIT_W-1:0]   hit_cnt_q;
  logic [POS_W-1:0]   pos_buf [LANES];
  logic [LANE_W-1:0]  lane_first;
  logic [LANE_W-1:0]  lane_next;
  res_t               res_q;

  function automatic logic [LANE_W-1:0] lowest_set(input logic [LANES-1:0] v);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) if (v[i]) r = LANE_W'(i);
    return r;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // winner's iteration request, clamped to the largest legal value
  always_comb begin
    ite_req   = i_req_ite[arb_idx*ITE_W +: ITE_W];
    ite_clamp = (ite_req > ITE_W'(MAX_ITE)) ? ITE_W'(MAX_ITE) : ite_req;
  end

  // next-entry selection: first hit on capture, next hit after an accept
  always_comb begin
    mask_next  = hit_mask & ~(LANES'(1) << res_q.lane);
    lane_first = lowest_set(i_aim_valid);
    lane_next  = lowest_set(mask_next);
    to_next    = to_cnt + 1'b1;
    ptr_next   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  end

  assign o_res_lane = res_q.lane;
  assign o_res_pos  = res_q.pos;

  // job sequencer; every output is a register updated on the transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      win_q       <= '0;
      o_gnt       <= '0;
      o_aim_start <= 1'b0;
      o_aim_ite   <= '0;
      to_cnt      <= '0;
      hit_mask    <= '0;
      hit_cnt_q   <= '0;
      res_q       <= '0;
      o_res_valid <= 1'b0;
      o_done      <= 1'b0;
      o_hit_cnt   <= '0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
      for (int i = 0; i < LANES; i++) pos_buf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            o_gnt       <= arb_gnt;
            win_q       <= arb_idx;
            o_aim_ite   <= ite_clamp;
            o_aim_start <= 1'b1;
            o_busy      <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          o_aim_start <= 1'b0;
          to_cnt      <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          to_cnt <= to_next;
          if (i_aim_finish) begin
            for (int i = 0; i < LANES; i++) pos_buf[i] <= i_aim_pos[i*POS_W +: POS_W];
            hit_mask  <= i_aim_valid;
            hit_cnt_q <= popcount(i_aim_valid);
            if (i_aim_valid != '0) begin
              res_q.lane  <= lane_first;
              res_q.pos   <= i_aim_pos[lane_first*POS_W +: POS_W];
              o_res_valid <= 1'b1;
              state       <= ST_DRAIN;
            end else begin
              // nothing to stream, so skip the empty drain cycle
              o_done    <= 1'b1;
              o_hit_cnt <= '0;
              o_timeout <= 1'b0;
              state     <= ST_DONE;
            end
          end else if (to_next == TO_LAST) begin
            o_done    <= 1'b1;
            o_hit_cnt <= '0;
            o_timeout <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (!o_res_valid) begin
            o_done    <= 1'b1;
            o_hit_cnt <= hit_cnt_q;
            o_timeout <= 1'b0;
            state     <= ST_DONE;
          end else if (i_res_ready) begin
            hit_mask <= mask_next;
            if (mask_next == '0) begin
              o_res_valid <= 1'b0;
              o_done      <= 1'b1;
              o_hit_cnt   <= hit_cnt_q;
              o_timeout   <= 1'b0;
              state       <= ST_DONE;
            end else begin
              res_q.lane <= lane_next;
              res_q.pos  <= pos_buf[lane_next];
            end
          end
        end
        ST_DONE: begin
          o_done    <= 1'b0;
          o_hit_cnt <= '0;
          o_timeout <= 1'b0;
          o_gnt     <= '0;
          o_busy    <= 1'b0;
          rr_ptr    <= ptr_next;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
